// File: rtl/pll_lock_supervisor.sv
// Reset sequencer and lock monitor for the SDRAM clock PLL, clocked by the PLL reference clock.
// Pulses the PLL reset, debounces lock, then releases downstream reset; retries on timeout or lock loss.
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 74250,
   parameter int LOCK_STABLE_CYCLES  = 1024
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       clr_status,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       lock_lost,
   output logic [3:0] retry_count
);

   localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

   localparam logic [1:0] S_RESET_PLL = 2'd0;
   localparam logic [1:0] S_WAIT_LOCK = 2'd1;
   localparam logic [1:0] S_STABLE    = 2'd2;
   localparam logic [1:0] S_RUN       = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] counter;
   logic             cnt_step;
   logic             retry_inc;
   logic             lost_set;
   logic             sync_meta;
   logic             locked_s;

   // NOTE: every signal written here gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_step  = 1'b1;
      retry_inc = 1'b0;
      lost_set  = 1'b0;
      case (state)
         S_RESET_PLL: begin
            if (counter == RST_LAST) state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = S_STABLE;
            end else if (counter == TIMEOUT_LAST) begin
               state_nxt = S_RESET_PLL;
               retry_inc = 1'b1;
            end
         end
         S_STABLE: begin
            // A captured drop outranks the final debounce cycle.
            if (!locked_s) state_nxt = S_WAIT_LOCK;
            else if (counter == STABLE_LAST) state_nxt = S_RUN;
         end
         S_RUN: begin
            cnt_step = 1'b0;
            if (!locked_s) begin
               state_nxt = S_RESET_PLL;
               lost_set  = 1'b1;
            end
         end
         default: state_nxt = S_RESET_PLL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync_meta <= 1'b0;
         locked_s  <= 1'b0;
      end else begin
         sync_meta <= pll_locked;
         locked_s  <= sync_meta;
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as the state register.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state     <= S_RESET_PLL;
         counter   <= '0;
         pll_rst   <= 1'b1;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
      end else begin
         state     <= state_nxt;
         pll_rst   <= (state_nxt == S_RESET_PLL);
         ready     <= (state_nxt == S_RUN);
         sys_reset <= (state_nxt != S_RUN);
         if (state_nxt != state) counter <= '0;
         else if (cnt_step)      counter <= counter + CNT_W'(1);
      end
   end

   // Set/increment events win over a coincident clear.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lock_lost   <= 1'b0;
         retry_count <= 4'd0;
      end else begin
         if (lost_set)        lock_lost <= 1'b1;
         else if (clr_status) lock_lost <= 1'b0;

         if (retry_inc) begin
            if (clr_status)                retry_count <= 4'd1;
            else if (retry_count != 4'hF)  retry_count <= retry_count + 4'd1;
         end else if (clr_status) begin
            retry_count <= 4'd0;
         end
      end
   end

endmodule
